// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for the decode-stage register file and its scoreboard.
package regfile_pkg;
    localparam int N_DEFAULT    = 32;
    localparam int L_DEFAULT    = 8;
    localparam int I_DEFAULT    = 20;
    localparam int R_DEFAULT    = 32;
    localparam int MAXF_DEFAULT = 3;

    typedef logic [I_DEFAULT-1:0][L_DEFAULT-1:0] vec_t;
    typedef logic [$clog2(MAXF_DEFAULT+1)-1:0]   pend_t;
endpackage

// File: rtl/regfile_scoreboard_sb_counters.sv
// sb_counters: per-register outstanding-write counters with hazard lookups for two sources and one destination.
module sb_counters
    import regfile_pkg::*;
#(
    parameter int  R    = R_DEFAULT,
    parameter int  MAXF = MAXF_DEFAULT,
    localparam int AW   = $clog2(R)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic [AW-1:0] inc_addr,
    input  logic          retire,
    input  logic [AW-1:0] retire_addr,
    input  logic [AW-1:0] a1,
    input  logic [AW-1:0] a2,
    input  logic [AW-1:0] a3,
    output logic          busy1,
    output logic          busy2,
    output logic          full3
);
    localparam int CW = $clog2(MAXF + 1);

    logic [CW-1:0] pend [R];
    logic [R-1:0]  inc_v;
    logic [R-1:0]  dec_v;

    // A register whose last outstanding write retires this cycle is served by the bypass.
    function automatic logic busy(input logic [AW-1:0] a);
        return pend[a] != '0 && !(retire && retire_addr == a && pend[a] == CW'(1));
    endfunction

    assign busy1 = busy(a1);
    assign busy2 = busy(a2);
    assign full3 = pend[a3] == CW'(MAXF);

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int r = 0; r < R; r++) begin
            inc_v[r] = inc && inc_addr == AW'(r);
            dec_v[r] = retire && retire_addr == AW'(r) && pend[r] != '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < R; r++) pend[r] <= '0;
        end else begin
            for (int r = 0; r < R; r++) begin
                if (inc_v[r] && !dec_v[r] && pend[r] != CW'(MAXF))
                    pend[r] <= pend[r] + CW'(1);
                else if (dec_v[r] && !inc_v[r])
                    pend[r] <= pend[r] - CW'(1);
            end
        end
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: scalar + vector register file with write-back bypass and a per-register hazard scoreboard.
// Define SB_STALL_CNT_EN to add stall_cnt_o, a saturating count of stalled cycles.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  N    = N_DEFAULT,
    parameter int  L    = L_DEFAULT,
    parameter int  I    = I_DEFAULT,
    parameter int  R    = R_DEFAULT,
    parameter int  MAXF = MAXF_DEFAULT,
    localparam int AW   = $clog2(R)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                issue_valid_i,
    input  logic                issue_use1_i,
    input  logic                issue_use2_i,
    input  logic                issue_wr_i,
    input  logic [AW-1:0]       A1_i,
    input  logic [AW-1:0]       A2_i,
    input  logic [AW-1:0]       A3_i,
    output logic                stall_o,
    output logic                issue_fire_o,
    input  logic                WE_S_i,
    input  logic                WE_V_i,
    input  logic                retire_i,
    input  logic [AW-1:0]       A3_WB_i,
    input  logic [N-1:0]        WD3_SCA_i,
    input  logic [I-1:0][L-1:0] WD3_VEC_i,
    output logic [N-1:0]        RD1_SCA_o,
    output logic [N-1:0]        RD2_SCA_o,
    output logic [I-1:0][L-1:0] RD1_VEC_o,
    output logic [I-1:0][L-1:0] RD2_VEC_o
`ifdef SB_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt_o
`endif
);
    logic [N-1:0]        sca [R];
    logic [I-1:0][L-1:0] vec [R];
    logic                busy1, busy2, full3;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int r = 0; r < R; r++) begin
                sca[r] <= '0;
                vec[r] <= '0;
            end
        end else begin
            if (WE_S_i) sca[A3_WB_i] <= WD3_SCA_i;
            if (WE_V_i) vec[A3_WB_i] <= WD3_VEC_i;
        end
    end

    assign RD1_SCA_o = (WE_S_i && A1_i == A3_WB_i) ? WD3_SCA_i : sca[A1_i];
    assign RD2_SCA_o = (WE_S_i && A2_i == A3_WB_i) ? WD3_SCA_i : sca[A2_i];
    assign RD1_VEC_o = (WE_V_i && A1_i == A3_WB_i) ? WD3_VEC_i : vec[A1_i];
    assign RD2_VEC_o = (WE_V_i && A2_i == A3_WB_i) ? WD3_VEC_i : vec[A2_i];

    // A full destination counter stalls even if a retire frees a slot this cycle.
    assign stall_o      = issue_valid_i && ((issue_use1_i && busy1) || (issue_use2_i && busy2) ||
                                            (issue_wr_i && full3));
    assign issue_fire_o = issue_valid_i && !stall_o;

    sb_counters #(.R(R), .MAXF(MAXF)) u_sb (
        .clk         (CLK),
        .rst_n       (RST),
        .inc         (issue_fire_o && issue_wr_i),
        .inc_addr    (A3_i),
        .retire      (retire_i),
        .retire_addr (A3_WB_i),
        .a1          (A1_i),
        .a2          (A2_i),
        .a3          (A3_i),
        .busy1       (busy1),
        .busy2       (busy2),
        .full3       (full3)
    );

`ifdef SB_STALL_CNT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) stall_cnt_o <= '0;
        else if (stall_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed plus random checks of regfile_scoreboard against an array-based reference model.
module tb_regfile_scoreboard;
    localparam int MAXF = 3;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         iv, u1, u2, wr, we_s, we_v, ret;
    logic [4:0]   a1, a2, a3, wb;
    logic [31:0]  wd_s;
    logic [159:0] wd_v;
    logic         stall_o, issue_fire_o;
    logic [31:0]  rd1_s, rd2_s;
    logic [159:0] rd1_v, rd2_v;
`ifdef SB_STALL_CNT_EN
    logic [31:0]  stall_cnt;
`endif

    int           compared = 0;
    int           mismatched = 0;
    logic [31:0]  sca_m [32];
    logic [159:0] vec_m [32];
    int           pend_m [32];
    logic [31:0]  cnt_m;

    always #5 CLK = ~CLK;

    regfile_scoreboard dut (
        .CLK           (CLK),
        .RST           (RST),
        .issue_valid_i (iv),
        .issue_use1_i  (u1),
        .issue_use2_i  (u2),
        .issue_wr_i    (wr),
        .A1_i          (a1),
        .A2_i          (a2),
        .A3_i          (a3),
        .stall_o       (stall_o),
        .issue_fire_o  (issue_fire_o),
        .WE_S_i        (we_s),
        .WE_V_i        (we_v),
        .retire_i      (ret),
        .A3_WB_i       (wb),
        .WD3_SCA_i     (wd_s),
        .WD3_VEC_i     (wd_v),
        .RD1_SCA_o     (rd1_s),
        .RD2_SCA_o     (rd2_s),
        .RD1_VEC_o     (rd1_v),
        .RD2_VEC_o     (rd2_v)
`ifdef SB_STALL_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit busy_m(input int a);
        return pend_m[a] != 0 && !(ret && int'(wb) == a && pend_m[a] == 1);
    endfunction

    function automatic bit stall_m();
        return iv && ((u1 && busy_m(int'(a1))) || (u2 && busy_m(int'(a2))) ||
                      (wr && pend_m[a3] == MAXF));
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            sca_m[r]  = '0;
            vec_m[r]  = '0;
            pend_m[r] = 0;
        end
        cnt_m = '0;
    endtask

    task automatic idle();
        {iv, u1, u2, wr, we_s, we_v, ret} = '0;
        {a1, a2, a3, wb} = '0;
        wd_s = '0;
        wd_v = '0;
    endtask

    task automatic check_all();
        bit s;
        s = stall_m();
        chk("stall", 160'(stall_o), 160'(s));
        chk("fire", 160'(issue_fire_o), 160'(iv && !s));
        chk("rd1_sca", 160'(rd1_s), 160'((we_s && a1 == wb) ? wd_s : sca_m[a1]));
        chk("rd2_sca", 160'(rd2_s), 160'((we_s && a2 == wb) ? wd_s : sca_m[a2]));
        chk("rd1_vec", rd1_v, (we_v && a1 == wb) ? wd_v : vec_m[a1]);
        chk("rd2_vec", rd2_v, (we_v && a2 == wb) ? wd_v : vec_m[a2]);
`ifdef SB_STALL_CNT_EN
        chk("stall_cnt", 160'(stall_cnt), 160'(cnt_m));
`endif
    endtask

    task automatic model_update();
        bit s, inc, dec;
        s   = stall_m();
        inc = iv && !s && wr;
        dec = ret && pend_m[wb] > 0;
        if (we_s) sca_m[wb] = wd_s;
        if (we_v) vec_m[wb] = wd_v;
        if (!(inc && dec && a3 == wb)) begin
            if (inc && pend_m[a3] < MAXF) pend_m[a3]++;
            if (dec) pend_m[wb]--;
        end
        if (s && cnt_m != '1) cnt_m++;
    endtask

    // Inputs are set just after a rising edge; outputs are checked on the falling edge.
    task automatic cyc();
        @(negedge CLK);
        check_all();
        @(posedge CLK);
        #1;
        model_update();
    endtask

    initial begin
        idle();
        model_reset();
        a1 = 5'd3;
        #12;
        chk("reset_stall", 160'(stall_o), 160'(0));
        chk("reset_rd1", 160'(rd1_s), 160'(0));
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        for (int k = 0; k < 16; k++) begin
            we_s = 1'b1;
            wb   = 5'(k);
            wd_s = 32'(k);
            a1   = 5'(k == 0 ? 0 : k - 1);
            we_s = 1'b1;
            cyc();
        end
        idle();
        a1 = 5'd15;
        a2 = 5'd9;
        #1;
        chk("write_read_15", 160'(rd1_s), 160'(32'd15));
        chk("write_read_9", 160'(rd2_s), 160'(32'd9));
        cyc();

        we_s = 1'b1;
        wb   = 5'd5;
        wd_s = 32'hA5A5_0005;
        a1   = 5'd5;
        #1;
        chk("bypass_sca", 160'(rd1_s), 160'(32'hA5A5_0005));
        cyc();

        idle();
        iv = 1'b1;
        wr = 1'b1;
        a3 = 5'd7;
        #1;
        chk("raw_issue_fire", 160'(issue_fire_o), 160'(1));
        cyc();
        wr = 1'b0;
        u1 = 1'b1;
        a1 = 5'd7;
        #1;
        chk("raw_stall", 160'(stall_o), 160'(1));
        cyc();
        ret  = 1'b1;
        wb   = 5'd7;
        we_v = 1'b1;
        wd_v = {20{8'h11}};
        #1;
        chk("raw_release", 160'(stall_o), 160'(0));
        chk("raw_vec_bypass", rd1_v, {20{8'h11}});
        cyc();

        idle();
        iv = 1'b1;
        wr = 1'b1;
        a3 = 5'd2;
        for (int k = 0; k < 3; k++) cyc();
        #1;
        chk("sat_stall", 160'(stall_o), 160'(1));
        cyc();
        ret = 1'b1;
        wb  = 5'd2;
        #1;
        chk("sat_stall_with_retire", 160'(stall_o), 160'(1));
        cyc();
        ret = 1'b0;
        #1;
        chk("sat_fire_after_retire", 160'(issue_fire_o), 160'(1));
        cyc();

        idle();
        iv = 1'b1;
        wr = 1'b1;
        a3 = 5'd9;
        cyc();
        ret = 1'b1;
        wb  = 5'd9;
        #1;
        chk("incdec_fire", 160'(issue_fire_o), 160'(1));
        cyc();
        ret = 1'b0;
        wr  = 1'b0;
        u1  = 1'b1;
        a1  = 5'd9;
        #1;
        chk("incdec_still_busy", 160'(stall_o), 160'(1));
        cyc();
        ret = 1'b1;
        #1;
        chk("incdec_retire_last", 160'(stall_o), 160'(0));
        cyc();

        idle();
        iv = 1'b1;
        wr = 1'b1;
        a3 = 5'd3;
        cyc();
        cyc();
        idle();
        RST = 1'b0;
        a1  = 5'd3;
        #2;
        model_reset();
        chk("rst_mid_stall", 160'(stall_o), 160'(0));
        chk("rst_mid_rd1", 160'(rd1_s), 160'(0));
`ifdef SB_STALL_CNT_EN
        chk("rst_mid_cnt", 160'(stall_cnt), 160'(0));
`endif
        iv = 1'b1;
        u1 = 1'b1;
        #1;
        chk("rst_mid_pend_clear", 160'(stall_o), 160'(0));
        idle();
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        iv = 1'b1;
        wr = 1'b1;
        a3 = 5'd3;
        cyc();
        wr = 1'b0;
        u1 = 1'b1;
        a1 = 5'd3;
        for (int k = 0; k < 4; k++) cyc();
        idle();
        ret = 1'b1;
        wb  = 5'd12;
        #1;
`ifdef SB_STALL_CNT_EN
        chk("stall_cnt_4", 160'(stall_cnt), 160'(4));
`endif
        cyc();

        for (int k = 0; k < 400; k++) begin
            iv   = 1'($urandom_range(0, 1));
            u1   = 1'($urandom_range(0, 1));
            u2   = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            a1   = 5'($urandom_range(0, 7));
            a2   = 5'($urandom_range(0, 7));
            a3   = 5'($urandom_range(0, 7));
            wb   = 5'($urandom_range(0, 7));
            ret  = 1'($urandom_range(0, 1));
            we_s = 1'($urandom_range(0, 1));
            we_v = 1'($urandom_range(0, 1));
            wd_s = $urandom;
            wd_v = {$urandom, $urandom, $urandom, $urandom, $urandom};
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Decode-stage register file with an integrated scoreboard.
- Parametrised successor of the scalar/vector register file: holds one N-bit scalar bank and one I-lane vector bank (L bits per lane), both with R entries.
- Two read ports with write-back bypass.
- Tracks in-flight writes per register and raises a stall when a decoded instruction reads or overwrites a register still owed by the pipeline.
- Sits between Pipe_IF_ID and Pipe_ID_EX. stall_o gates the IF/ID pipe and drives enable_i of Pipe_ID_EX.

Parameters:
N, 32, scalar register width
L, 8, vector lane width
I, 20, vector lane count
R, 32, register count per bank (power of two, >=2)
AW, $clog2(R), address width (derived, localparam)
MAXF, 3, max outstanding writes per register (1..7)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-low reset
issue_valid_i  in  1  decoded instruction present in ID
issue_use1_i  in  1  instruction reads A1
issue_use2_i  in  1  instruction reads A2
issue_wr_i  in  1  instruction will write A3
A1_i  in  AW  read address 1
A2_i  in  AW  read address 2
A3_i  in  AW  destination address
stall_o  out  1  hazard, hold ID
issue_fire_o  out  1  issue_valid_i & !stall_o
WE_S_i  in  1  scalar write-back enable
WE_V_i  in  1  vector write-back enable
retire_i  in  1  write-back completes one outstanding write to A3_WB_i
A3_WB_i  in  AW  write-back address
WD3_SCA_i  in  N  scalar write data
WD3_VEC_i  in  I*L  vector write data, packed [I-1:0][L-1:0]
RD1_SCA_o  out  N  scalar read 1
RD2_SCA_o  out  N  scalar read 2
RD1_VEC_o  out  I*L  vector read 1
RD2_VEC_o  out  I*L  vector read 2

Behaviour:
- Reset (RST low, asynchronous):
  - All scalar and vector entries are cleared to 0.
  - All pending counters are cleared to 0.
  - Stall counter (if present) is cleared to 0.
  - Outputs are therefore 0 while reset is held and stall_o = 0.
  - Reset mid-operation discards all outstanding writes. Later retire_i pulses to a zero counter are ignored.
- Writes occur on the rising edge of CLK.
  - WE_S_i writes WD3_SCA_i into the scalar bank at A3_WB_i.
  - WE_V_i writes WD3_VEC_i into the vector bank at A3_WB_i.
  - Both enables may be set in the same cycle.
- Reads are combinational (0-cycle latency).
  - RDx_SCA_o = WD3_SCA_i when WE_S_i and Ax_i == A3_WB_i; otherwise the stored value.
  - The vector bank uses the same rule with WE_V_i.
- Scoreboard: one counter per register, width $clog2(MAXF+1), named pend[r].
- stall_o = issue_valid_i & ( (issue_use1_i & busy(A1_i)) | (issue_use2_i & busy(A2_i)) | (issue_wr_i & pend[A3_i]==MAXF) ).
  - busy(a) = pend[a] != 0, except busy(a) = 0 when retire_i & A3_WB_i == a & pend[a] == 1. Bypass covers that case.
- Counter update per clock edge:
  - inc = issue_fire_o & issue_wr_i
  - dec = retire_i & pend[A3_WB_i] != 0
  - When inc and dec target the same register, the count is unchanged.
  - Otherwise each update is applied independently.
  - The count never exceeds MAXF and never goes below 0.
- A1 == A2 == A3 within one instruction is legal. Only sources are checked against the prior count.

Optional Feature:
Macro SB_STALL_CNT_EN.
- Defined: adds output port stall_cnt_o (out, 32 bits).
  - Increments on each clock where stall_o = 1, saturating at 32'hFFFF_FFFF.
  - Reset to 0.
- Undefined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Package regfile_pkg holds:
  - vec_t typedef (logic [I-1:0][L-1:0] with the default parameters)
  - pend_t counter typedef
  - constant MAXF_DEFAULT
- One sub-module, sb_counters, owns the pend array, the inc/dec logic and busy().
  - It exports busy1, busy2 and full3.
- The top level holds both banks, the bypass muxes and the stall equation.

Test Plan:
1. Reset, then write scalar reg k = k for k = 0..15 with WE_S_i and no retire -> reading A1 = k in the next cycle gives RD1_SCA_o == k. stall_o stays 0.
2. Same-cycle bypass: WE_S_i = 1, A3_WB_i = 5, WD3_SCA_i = 32'hA5A5_0005, A1_i = 5 -> RD1_SCA_o == 32'hA5A5_0005 in that cycle.
3. RAW hazard: issue writes r7 (fire). Next cycle issue reads A1 = 7 -> stall_o = 1. Apply retire_i with A3_WB_i = 7 and WE_V_i, with lanes = 0x11 -> stall_o drops in the same cycle and RD1_VEC_o lanes == 0x11.
4. Saturation: fire 3 writes to r2 with no retire -> 4th write issue to r2 gives stall_o = 1. One retire -> pend[2] = 2 and the write fires.
5. Simultaneous inc/dec on r9 with pend = 1 -> pend stays 1. Issue reading r9 stalls.
6. Assert RST low while pend[3] = 2 -> pend cleared, stall_o = 0, RD1_SCA_o == 0. With SB_STALL_CNT_EN, stall_cnt_o == 0 and it counts 4 after 4 stalled cycles.
